render_write_arbiter: RTL

RENDER_WRITE_ARBITER -- requirements
Module: render_write_arbiter

---
 rtl/render_pkg.sv | 21 ++
 rtl/wrap_counter.sv | 48 ++++
 rtl/render_write_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/render_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// render_pkg : shared widths, defaults and arbiter state type
// Rev 1.0
// ---------------------------------------------------------------
package render_pkg;

   localparam int FB_ADDR_W          = 17;
   localparam int PIXEL_W            = 12;
   localparam int Z_W                = 8;
   localparam int NUM_PIXELS_DEFAULT = 76800;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CLEAR = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ---------------------------------------------------------------
// wrap_counter : loadable up/down counter that holds at a terminal value
// Rev 1.0
// ---------------------------------------------------------------
module wrap_counter
   import render_pkg::*;
#(
   parameter int WIDTH = FB_ADDR_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   input  logic             i_down,
   input  logic [WIDTH-1:0] i_term_val,
   output logic [WIDTH-1:0] o_count,
   output logic [WIDTH-1:0] o_count_next,
   output logic             o_term
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_load) begin
         count_d = i_load_val;
      end else if (i_en && (count_q != i_term_val)) begin
         count_d = i_down ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_count      = count_q;
   assign o_count_next = count_d;
   assign o_term       = (count_q == i_term_val);

endmodule
`default_nettype wire

// File: rtl/render_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------
// render_write_arbiter : muxes fragment writes with a full-frame fb/zb clear
// Rev 1.0
// ---------------------------------------------------------------
module render_write_arbiter
   import render_pkg::*;
#(
   parameter int             NUM_PIXELS   = NUM_PIXELS_DEFAULT,
   parameter int             DRAIN_CYCLES = 4,
   parameter logic [Z_W-1:0] ZB_CLEAR_VAL = 8'hFF
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clear_start,
   input  logic [PIXEL_W-1:0]   i_clear_color,
   input  logic [FB_ADDR_W-1:0] i_frag_fb_addr,
   input  logic                 i_frag_fb_we,
   input  logic [PIXEL_W-1:0]   i_frag_fb_pixel,
   input  logic [FB_ADDR_W-1:0] i_frag_zb_addr,
   input  logic                 i_frag_zb_we,
   input  logic [Z_W-1:0]       i_frag_zb_val,
   output logic [FB_ADDR_W-1:0] o_fb_addr,
   output logic                 o_fb_we,
   output logic [PIXEL_W-1:0]   o_fb_pixel,
   output logic [FB_ADDR_W-1:0] o_zb_addr,
   output logic                 o_zb_we,
   output logic [Z_W-1:0]       o_zb_val,
   output logic                 o_raster_stall,
   output logic                 o_busy,
   output logic                 o_clear_done,
   output logic                 o_frag_drop
);

   localparam logic [FB_ADDR_W-1:0] LAST_ADDR  = FB_ADDR_W'(NUM_PIXELS - 1);
   localparam logic [FB_ADDR_W-1:0] DRAIN_LOAD = FB_ADDR_W'(DRAIN_CYCLES);
   localparam logic [FB_ADDR_W-1:0] DRAIN_TERM = FB_ADDR_W'(1);

   arb_state_t state_q, state_d;
   logic [PIXEL_W-1:0] color_q, color_d;

   logic                 cnt_load;
   logic [FB_ADDR_W-1:0] cnt_load_val;
   logic                 cnt_en;
   logic                 cnt_down;
   logic [FB_ADDR_W-1:0] cnt_term_val;
   logic [FB_ADDR_W-1:0] cnt_value;
   logic [FB_ADDR_W-1:0] cnt_next;
   logic                 cnt_term;

   logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic                 fb_we_q, fb_we_d;
   logic [PIXEL_W-1:0]   fb_pixel_q, fb_pixel_d;
   logic [FB_ADDR_W-1:0] zb_addr_q, zb_addr_d;
   logic                 zb_we_q, zb_we_d;
   logic [Z_W-1:0]       zb_val_q, zb_val_d;
   logic                 stall_q, stall_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 drop_q, drop_d;

   logic clear_slot;
   logic frag_blocked;

   // One counter serves both phases: counts down through the drain, then up over pixels.
   wrap_counter #(
      .WIDTH (FB_ADDR_W)
   ) u_counter (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_load       (cnt_load),
      .i_load_val   (cnt_load_val),
      .i_en         (cnt_en),
      .i_down       (cnt_down),
      .i_term_val   (cnt_term_val),
      .o_count      (cnt_value),
      .o_count_next (cnt_next),
      .o_term       (cnt_term)
   );

   always_comb begin
      state_d      = state_q;
      color_d      = color_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_en       = 1'b0;
      cnt_down     = 1'b0;
      cnt_term_val = LAST_ADDR;
      case (state_q)
         ST_IDLE: begin
            if (i_clear_start) begin
               state_d      = ST_DRAIN;
               color_d      = i_clear_color;
               cnt_load     = 1'b1;
               cnt_load_val = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            cnt_term_val = DRAIN_TERM;
            cnt_down     = 1'b1;
            if (cnt_term) begin
               state_d      = ST_CLEAR;
               cnt_load     = 1'b1;
               cnt_load_val = '0;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_CLEAR: begin
            if (cnt_term) begin
               state_d = ST_DONE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_DONE: begin
            state_d      = ST_IDLE;
            cnt_load     = 1'b1;
            cnt_load_val = '0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output registers follow the state being entered, so the port view lines up with
   // the state: the first clear write lands in the first CLEAR cycle.
   always_comb begin
      clear_slot   = (state_d == ST_CLEAR);
      frag_blocked = clear_slot || (state_q == ST_CLEAR);

      fb_we_d    = 1'b0;
      fb_addr_d  = i_frag_fb_addr;
      fb_pixel_d = i_frag_fb_pixel;
      zb_we_d    = 1'b0;
      zb_addr_d  = i_frag_zb_addr;
      zb_val_d   = i_frag_zb_val;

      if (clear_slot) begin
         fb_we_d    = 1'b1;
         fb_addr_d  = cnt_next;
         fb_pixel_d = color_q;
         zb_we_d    = 1'b1;
         zb_addr_d  = cnt_next;
         zb_val_d   = ZB_CLEAR_VAL;
      end else if (!frag_blocked) begin
         fb_we_d = i_frag_fb_we;
         zb_we_d = i_frag_zb_we;
      end

      stall_d = (state_d != ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
      drop_d  = drop_q || (frag_blocked && (i_frag_fb_we || i_frag_zb_we));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         color_q    <= '0;
         fb_addr_q  <= '0;
         fb_we_q    <= 1'b0;
         fb_pixel_q <= '0;
         zb_addr_q  <= '0;
         zb_we_q    <= 1'b0;
         zb_val_q   <= '0;
         stall_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         color_q    <= color_d;
         fb_addr_q  <= fb_addr_d;
         fb_we_q    <= fb_we_d;
         fb_pixel_q <= fb_pixel_d;
         zb_addr_q  <= zb_addr_d;
         zb_we_q    <= zb_we_d;
         zb_val_q   <= zb_val_d;
         stall_q    <= stall_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         drop_q     <= drop_d;
      end
   end

   assign o_fb_addr      = fb_addr_q;
   assign o_fb_we        = fb_we_q;
   assign o_fb_pixel     = fb_pixel_q;
   assign o_zb_addr      = zb_addr_q;
   assign o_zb_we        = zb_we_q;
   assign o_zb_val       = zb_val_q;
   assign o_raster_stall = stall_q;
   assign o_busy         = busy_q;
   assign o_clear_done   = done_q;
   assign o_frag_drop    = drop_q;

endmodule
`default_nettype wire
